// File: rtl/nv_memory_ctrl_if.sv
// Requester and erase handshake bundle between the two nv_memory clients and the controller.
// master = requester/test side, slave = nv_memory_ctrl.
interface nv_memory_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_ack;
    logic [DATA_W-1:0] a_rdata;
    logic              a_err;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_ack;
    logic [DATA_W-1:0] b_rdata;
    logic              b_err;

    logic              erase_req;
    logic              erase_busy;
    logic              erase_done;

    modport master (
        output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, erase_req,
        input  a_ack, a_rdata, a_err, b_ack, b_rdata, b_err, erase_busy, erase_done
    );

    modport slave (
        input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, erase_req,
        output a_ack, a_rdata, a_err, b_ack, b_rdata, b_err, erase_busy, erase_done
    );
endinterface

// File: rtl/nv_memory_ctrl.sv
// Arbitrates loader (A) and key reader (B) onto the nv_memory macro, with erase taking priority; NV_MEM_CTRL_VERIFY_EN adds write read-back.
// Latency: read ack in cycle RD_LAT+2, write ack in cycle WR_CYCLES+1 (+RD_LAT+1 with verify), erase busy ERASE_CYCLES then done pulse.
// Backpressure: requests are held until ack; only sampled in IDLE, so anything arriving mid-access or mid-erase simply waits.
module nv_memory_ctrl #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 64,
    parameter int WR_CYCLES    = 1,
    parameter int RD_LAT       = 1,
    parameter int ERASE_CYCLES = 16
) (
    input  logic              fpga_clk,
    input  logic              fpga_rst,
    nv_memory_ctrl_if.slave   bus,
    output logic              mem_erase,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr_in,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);
    localparam int RD_CYC  = RD_LAT + 1;
    localparam int CNT_MAX = (WR_CYCLES > ERASE_CYCLES)
                           ? ((WR_CYCLES > RD_CYC) ? WR_CYCLES : RD_CYC)
                           : ((ERASE_CYCLES > RD_CYC) ? ERASE_CYCLES : RD_CYC);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE, WRITE, READ, DONE, ERASE
`ifdef NV_MEM_CTRL_VERIFY_EN
        , VERIFY
`endif
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             gnt_b;
    logic             last_b;
    logic             pick_b;
    logic             pick_we;

    // B wins only when A is absent or A was served last.
    assign pick_b  = bus.b_req && (!bus.a_req || !last_b);
    assign pick_we = pick_b ? bus.b_we : bus.a_we;

`ifndef NV_MEM_CTRL_VERIFY_EN
    assign bus.a_err = 1'b0;
    assign bus.b_err = 1'b0;
`endif

    always_ff @(posedge fpga_clk) begin
        if (fpga_rst) begin
            state          <= IDLE;
            cnt            <= '0;
            gnt_b          <= 1'b0;
            last_b         <= 1'b1;
            mem_rw         <= 1'b1;
            mem_erase      <= 1'b0;
            mem_addr_in    <= '0;
            mem_data_in    <= '0;
            bus.a_ack      <= 1'b0;
            bus.b_ack      <= 1'b0;
            bus.a_rdata    <= '0;
            bus.b_rdata    <= '0;
            bus.erase_busy <= 1'b0;
            bus.erase_done <= 1'b0;
`ifdef NV_MEM_CTRL_VERIFY_EN
            bus.a_err      <= 1'b0;
            bus.b_err      <= 1'b0;
`endif
        end else begin
            bus.a_ack      <= 1'b0;
            bus.b_ack      <= 1'b0;
            bus.erase_done <= 1'b0;
`ifdef NV_MEM_CTRL_VERIFY_EN
            bus.a_err      <= 1'b0;
            bus.b_err      <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.erase_req) begin
                        state          <= ERASE;
                        mem_erase      <= 1'b1;
                        bus.erase_busy <= 1'b1;
                        cnt            <= CNT_W'(ERASE_CYCLES - 1);
                    end else if (bus.a_req || bus.b_req) begin
                        gnt_b       <= pick_b;
                        last_b      <= pick_b;
                        mem_addr_in <= pick_b ? bus.b_addr  : bus.a_addr;
                        mem_data_in <= pick_b ? bus.b_wdata : bus.a_wdata;
                        if (pick_we) begin
                            state  <= WRITE;
                            mem_rw <= 1'b0;
                            cnt    <= CNT_W'(WR_CYCLES - 1);
                        end else begin
                            state  <= READ;
                            cnt    <= CNT_W'(RD_LAT);
                        end
                    end
                end
                WRITE: begin
                    if (cnt == '0) begin
                        mem_rw <= 1'b1;
`ifdef NV_MEM_CTRL_VERIFY_EN
                        state  <= VERIFY;
                        cnt    <= CNT_W'(RD_LAT);
`else
                        state     <= DONE;
                        bus.a_ack <= !gnt_b;
                        bus.b_ack <= gnt_b;
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                READ: begin
                    if (cnt == '0) begin
                        state     <= DONE;
                        bus.a_ack <= !gnt_b;
                        bus.b_ack <= gnt_b;
                        if (gnt_b) bus.b_rdata <= mem_data_out;
                        else       bus.a_rdata <= mem_data_out;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`ifdef NV_MEM_CTRL_VERIFY_EN
                VERIFY: begin
                    if (cnt == '0) begin
                        state     <= DONE;
                        bus.a_ack <= !gnt_b;
                        bus.b_ack <= gnt_b;
                        bus.a_err <= !gnt_b && (mem_data_out != mem_data_in);
                        bus.b_err <= gnt_b && (mem_data_out != mem_data_in);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`endif
                DONE: state <= IDLE;
                ERASE: begin
                    if (cnt == '0) begin
                        state          <= IDLE;
                        mem_erase      <= 1'b0;
                        bus.erase_busy <= 1'b0;
                        bus.erase_done <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/nv_memory_ctrl.md
Name: nv_memory_ctrl

Overview:
Sequencing and arbitration controller in front of the 256 x 64 nv_memory macro. Two requesters share the macro: A is the bitstream loader and B is the key/config reader. An erase sequencer has priority over new grants. The block owns every macro control pin (mem_rw, mem_addr_in, mem_data_in, mem_erase), enforces access timing, and returns read data over a req/ack handshake.

Parameters:
ADDR_W, 8, macro address width
DATA_W, 64, macro data width
WR_CYCLES, 1, cycles mem_rw held low per write (>=1)
RD_LAT, 1, cycles from address applied to mem_data_out valid (>=0)
ERASE_CYCLES, 16, cycles mem_erase held high per erase (>=1)

Ports:
fpga_clk  in  1  single clock
fpga_rst  in  1  synchronous reset, active-high
a_req  in  1  requester A request, held with fields until a_ack
a_we  in  1  1=write, 0=read
a_addr  in  ADDR_W  A address
a_wdata  in  DATA_W  A write data
a_ack  out  1  one-cycle completion pulse
a_rdata  out  DATA_W  read data, valid when a_ack=1 on a read
a_err  out  1  verify mismatch, valid with a_ack (see Optional Feature)
b_req, b_we, b_addr, b_wdata, b_ack, b_rdata, b_err  same as A, for requester B
erase_req  in  1  level; erase started when sampled high in IDLE
erase_busy  out  1  high while ERASE active
erase_done  out  1  one-cycle pulse at erase end
mem_erase  out  1  to macro
mem_rw  out  1  to macro, 0=write, 1=read
mem_addr_in  out  ADDR_W  to macro
mem_data_in  out  DATA_W  to macro
mem_data_out  in  DATA_W  from macro

Behaviour:
- Connects to nv_memory: fpga_clk, fpga_rst, and the four mem_* outputs plus mem_data_out.
- All outputs are registered. Reset values: mem_rw=1, mem_erase=0, mem_addr_in=0, mem_data_in=0, all ack/err/done/busy=0, rdata=0, last_grant=B (so A wins first tie).
- mem_rw idles at 1. A write never occurs outside WRITE state.
- FSM states: IDLE, WRITE, READ, VERIFY (macro only), DONE, ERASE.
- IDLE, priority order:
  - erase_req -> ERASE.
  - Else exactly one req -> grant it.
  - Else both reqs -> grant the requester not in last_grant, then update last_grant.
  - On grant, latch addr/wdata/we onto mem_* and move to WRITE or READ.
- WRITE: mem_rw=0 for WR_CYCLES cycles, then mem_rw=1 and move to DONE (or VERIFY).
- READ: mem_rw=1 and address held RD_LAT+1 cycles. On the last cycle, capture mem_data_out into the granted rdata. Move to DONE.
- DONE: one cycle. The granted ack=1 and its rdata is stable. Next state is IDLE. The requester drops req in the cycle after ack. A req still high in IDLE is treated as a new request.
- Read latency: req sampled at edge 0 -> ack high in cycle RD_LAT+2. With defaults, ack arrives in cycle 3.
- Write latency: ack high in cycle WR_CYCLES+1.
- The non-granted rdata register holds its value. The non-granted ack stays 0.
- ERASE:
  - mem_erase=1 and erase_busy=1 for ERASE_CYCLES cycles, with mem_rw=1.
  - Then erase_done pulses for 1 cycle (mem_erase=0) and the FSM returns to IDLE.
  - erase_req arriving during an access waits; the in-flight access is never aborted.
  - Requests arriving during ERASE wait. They are served afterwards in round-robin order.
- A request to the macro is considered only when sampled in IDLE. Field changes while a request is pending are a protocol violation and their effect is undefined.
- fpga_rst in any state: return to IDLE with reset values on the next edge. Any in-flight ack is dropped and mem_rw returns to 1 immediately.
- Counters are sized to the largest of WR_CYCLES, RD_LAT+1, ERASE_CYCLES. Address wrap-around is not applicable because each access is a single word.

Optional Feature:
NV_MEM_CTRL_VERIFY_EN
- Defined:
  - After WRITE, enter VERIFY: mem_rw=1 at the same address for RD_LAT+1 cycles.
  - Compare the captured mem_data_out against the latched wdata.
  - In DONE, err=1 with ack if they mismatch. Write ack latency grows by RD_LAT+1.
  - Reads always return err=0.
- Undefined: no VERIFY state, and a_err and b_err are tied 0.

Test Plan:
1. Write then read, single requester: A writes addr 0 = 256 -> mem_rw low exactly WR_CYCLES cycles, a_ack at cycle 2. A reads addr 0 -> a_ack at cycle 3 with a_rdata=256.
2. Round-robin tie: A and B both read (A addr 1 = 555, B addr 200 = 2560) held high for 4 transactions -> grant order A,B,A,B. Each ack carries the correct data, and the other ack stays 0.
3. Erase during access: erase_req asserted one cycle after B's read is granted -> B's read completes first. Then mem_erase is high for 16 cycles and erase_done pulses. A subsequent read of addr 200 returns the macro's erased value.
4. Reset mid-write: fpga_rst at the second WRITE cycle with WR_CYCLES=4 -> next cycle mem_rw=1, no ack, FSM in IDLE, last_grant=B.
5. Idle safety: no requests for 50 cycles -> mem_rw=1 and mem_erase=0 throughout.
6. VERIFY_EN build: force mem_data_out to a stuck value while A writes 0xA5 -> a_ack with a_err=1 at cycle WR_CYCLES+RD_LAT+2. A matching write gives a_err=0.
